// File: rtl/frame_disassembly.sv
// frame_disassembly: receive-side MHP frame parser.
// Rebuilds dst/src/size/dir/type/payload from a 51-byte stream, verifies the
// 16-bit shifted-sum checksum and strobes o_valid / o_crc_err / o_gap_err.
// Optional macro FRAME_DISASM_DST_FILTER_EN: drop good frames whose dst is
// neither MY_ADDR nor broadcast 16'hFFFF.
module frame_disassembly #(
    parameter int unsigned MHP_FRAME_LEN = 51,
    parameter int unsigned GAP_TIMEOUT   = 4,
    parameter logic [15:0] MY_ADDR       = 16'h0001
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   i_rdata,
    input  logic         i_rvalid,
    output logic [15:0]  o_dst,
    output logic [15:0]  o_src,
    output logic [15:0]  o_size,
    output logic         o_dir,
    output logic [6:0]   o_type,
    output logic [335:0] o_payload,
    output logic         o_valid,
    output logic         o_crc_err,
    output logic         o_gap_err,
    output logic         busy
);

    localparam int unsigned FrameBits = MHP_FRAME_LEN * 8;
    localparam logic [5:0]  LastIdx   = 6'(MHP_FRAME_LEN - 1);
    localparam logic [5:0]  CrcIdx    = 6'(MHP_FRAME_LEN - 2);
    localparam logic [3:0]  GapLimit  = 4'(GAP_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StRecv, StCheck} state_e;

    state_e                 state_q, state_d;
    logic [5:0]             ctr_q, ctr_d;
    logic [15:0]            acc_q, acc_d;
    logic [3:0]             gap_q, gap_d;
    logic [FrameBits-1:0]   sh_q, sh_d;
    logic [15:0]            dst_q, dst_d, src_q, src_d, size_q, size_d;
    logic                   dir_q, dir_d;
    logic [6:0]             type_q, type_d;
    logic [335:0]           pay_q, pay_d;
    logic                   valid_q, valid_d, crc_err_q, crc_err_d, gap_err_q, gap_err_d;

    // Frame as it looks once the current byte is shifted in; byte j sits at [8*j +: 8]
    // after all 51 bytes have arrived.
    logic [FrameBits-1:0]   frame;
    logic [15:0]            acc_add;
    logic [3:0]             gap_inc;
    logic                   crc_ok;
    logic                   addr_ok;

    assign frame   = {i_rdata, sh_q[FrameBits-1:8]};
    assign acc_add = {8'h00, i_rdata} << ctr_q[1:0];
    assign gap_inc = gap_q + 4'd1;
    assign crc_ok  = ({frame[399:392], frame[407:400]} == acc_q);

`ifdef FRAME_DISASM_DST_FILTER_EN
    assign addr_ok = (frame[15:0] == MY_ADDR) || (frame[15:0] == 16'hFFFF);
`else
    assign addr_ok = 1'b1;
    logic unused_my_addr;
    assign unused_my_addr = ^MY_ADDR;
`endif

    // Next-state logic. The checksum verdict is taken on the edge that accepts
    // byte 50 so the registered strobes are visible during the CHECK cycle.
    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        acc_d     = acc_q;
        gap_d     = gap_q;
        sh_d      = sh_q;
        dst_d     = dst_q;
        src_d     = src_q;
        size_d    = size_q;
        dir_d     = dir_q;
        type_d    = type_q;
        pay_d     = pay_q;
        valid_d   = 1'b0;
        crc_err_d = 1'b0;
        gap_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_rvalid) begin
                    state_d = StRecv;
                    ctr_d   = 6'd1;
                    acc_d   = {8'h00, i_rdata};
                    gap_d   = 4'd0;
                    sh_d    = frame;
                end
            end
            StRecv: begin
                if (i_rvalid) begin
                    sh_d  = frame;
                    gap_d = 4'd0;
                    ctr_d = ctr_q + 6'd1;
                    if (ctr_q < CrcIdx) begin
                        acc_d = acc_q + acc_add;
                    end
                    if (ctr_q == LastIdx) begin
                        state_d = StCheck;
                        ctr_d   = 6'd0;
                        if (!crc_ok) begin
                            crc_err_d = 1'b1;
                        end else if (addr_ok) begin
                            valid_d = 1'b1;
                            dst_d   = frame[15:0];
                            src_d   = frame[31:16];
                            size_d  = frame[47:32];
                            dir_d   = frame[55];
                            type_d  = frame[54:48];
                            pay_d   = frame[391:56];
                        end
                    end
                end else begin
                    gap_d = gap_inc;
                    if (gap_inc == GapLimit) begin
                        gap_err_d = 1'b1;
                        state_d   = StIdle;
                        ctr_d     = 6'd0;
                        gap_d     = 4'd0;
                    end
                end
            end
            StCheck: begin
                // Any byte presented here is ignored.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ctr_q     <= '0;
            acc_q     <= '0;
            gap_q     <= '0;
            sh_q      <= '0;
            dst_q     <= '0;
            src_q     <= '0;
            size_q    <= '0;
            dir_q     <= 1'b0;
            type_q    <= '0;
            pay_q     <= '0;
            valid_q   <= 1'b0;
            crc_err_q <= 1'b0;
            gap_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctr_q     <= ctr_d;
            acc_q     <= acc_d;
            gap_q     <= gap_d;
            sh_q      <= sh_d;
            dst_q     <= dst_d;
            src_q     <= src_d;
            size_q    <= size_d;
            dir_q     <= dir_d;
            type_q    <= type_d;
            pay_q     <= pay_d;
            valid_q   <= valid_d;
            crc_err_q <= crc_err_d;
            gap_err_q <= gap_err_d;
        end
    end

    assign o_dst     = dst_q;
    assign o_src     = src_q;
    assign o_size    = size_q;
    assign o_dir     = dir_q;
    assign o_type    = type_q;
    assign o_payload = pay_q;
    assign o_valid   = valid_q;
    assign o_crc_err = crc_err_q;
    assign o_gap_err = gap_err_q;
    assign busy      = (state_q != StIdle);

endmodule
